// File: rtl/fadd_pipe.sv
// fadd_pipe: 3-stage IEEE-754-style add/sub, RNE, flush-to-zero.
// Stages: align -> add/lzc -> normalise/round/pack, valid/ready stall.
module fadd_pipe #(
  parameter int EW = 8,
  parameter int MW = 23,
  localparam int W = 1 + EW + MW
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         sub,
  input  logic [W-1:0] x1,
  input  logic [W-1:0] x2,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] y,
  output logic [2:0]   flags
);

  localparam int SW = MW + 4;
  localparam int LW = $clog2(SW + 1);
  localparam int XW = EW + 2;
  localparam int RW = MW + 2;
  localparam logic [EW-1:0] EONE = '1;
  localparam logic signed [XW-1:0] EMAX = XW'((1 << EW) - 1);

  typedef struct packed {
    logic          nan;
    logic          inf;
    logic          isgn;
    logic          sgn;
    logic          zsgn;
    logic          esub;
    logic [EW-1:0] exp;
    logic [SW-1:0] a;
    logic [SW-1:0] b;
  } st1_t;

  typedef struct packed {
    logic          nan;
    logic          inf;
    logic          isgn;
    logic          sgn;
    logic          zsgn;
    logic [EW-1:0] exp;
    logic [SW:0]   sum;
    logic [LW-1:0] lz;
  } st2_t;

  function automatic logic [LW-1:0] lzc(
    input logic [SW-1:0] v
  );
    lzc = LW'(SW);
    for (int i = 0; i < SW; i++)
      if (v[i]) lzc = LW'(SW - 1 - i);
  endfunction

  logic en;
  logic v1, v2;
  st1_t s1, s1_n;
  st2_t s2, s2_n;
  logic [W-1:0] y_n;
  logic [2:0] f_n;

  assign en = !out_valid || out_ready;
  assign in_ready = en;

  logic sa, sb, za, zb, ia, ib, na, nb, agb;
  logic [EW-1:0] ea, eb, ediff;
  logic [MW-1:0] ma, mb;
  logic [EW+MW-1:0] maga, magb;
  logic [MW:0] sga, sgb;
  logic [31:0] sh;
  logic [2*SW-1:0] wide;

  always_comb begin
    sa = x1[W-1];
    sb = x2[W-1] ^ sub;
    ea = x1[W-2:MW];
    eb = x2[W-2:MW];
    ma = x1[MW-1:0];
    mb = x2[MW-1:0];
    za = ea == '0;
    zb = eb == '0;
    ia = ea == EONE && ma == '0;
    ib = eb == EONE && mb == '0;
    na = ea == EONE && ma != '0;
    nb = eb == EONE && mb != '0;
    // denormals compare and add as exact zeros
    maga = za ? '0 : x1[W-2:0];
    magb = zb ? '0 : x2[W-2:0];
    sga = za ? '0 : {1'b1, ma};
    sgb = zb ? '0 : {1'b1, mb};
    agb = maga >= magb;
    ediff = agb ? ea - eb : eb - ea;
    sh = (32'(ediff) > 32'(SW)) ? 32'(SW) : 32'(ediff);
    wide = {(agb ? sgb : sga), 3'b000, {SW{1'b0}}} >> sh;
    s1_n = '0;
    s1_n.nan = na | nb | (ia & ib & (sa ^ sb));
    s1_n.inf = ia | ib;
    s1_n.isgn = ia ? sa : sb;
    s1_n.sgn = agb ? sa : sb;
    s1_n.zsgn = sa & sb;
    s1_n.esub = sa ^ sb;
    s1_n.exp = agb ? ea : eb;
    s1_n.a = {(agb ? sga : sgb), 3'b000};
    s1_n.b = {wide[2*SW-1:SW+1],
              wide[SW] | (|wide[SW-1:0])};
  end

  always_comb begin
    s2_n = '0;
    s2_n.nan = s1.nan;
    s2_n.inf = s1.inf;
    s2_n.isgn = s1.isgn;
    s2_n.sgn = s1.sgn;
    s2_n.zsgn = s1.zsgn;
    s2_n.exp = s1.exp;
    s2_n.sum = s1.esub ? {1'b0, s1.a} - {1'b0, s1.b}
                       : {1'b0, s1.a} + {1'b0, s1.b};
    s2_n.lz = lzc(s2_n.sum[SW-1:0]);
  end

  logic cy, g, rs, up;
  logic [SW-1:0] nrm;
  logic [MW:0] sig;
  logic [RW-1:0] mr;
  logic [MW-1:0] frac;
  logic signed [XW-1:0] ex;

  always_comb begin
    cy = s2.sum[SW];
    nrm = cy ? {s2.sum[SW:2], s2.sum[1] | s2.sum[0]}
             : s2.sum[SW-1:0] << s2.lz;
    sig = nrm[SW-1:3];
    g = nrm[2];
    rs = |nrm[1:0];
    up = g & (rs | sig[0]);
    mr = {1'b0, sig} + RW'(up);
    frac = mr[MW+1] ? mr[MW:1] : mr[MW-1:0];
    ex = cy ? XW'(s2.exp) + XW'(1)
            : XW'(s2.exp) - XW'(s2.lz);
    ex = ex + XW'(mr[MW+1]);
    y_n = {s2.sgn, ex[EW-1:0], frac};
    f_n = 3'b000;
    if (s2.nan) begin
      y_n = {1'b0, EONE, 1'b1, {(MW-1){1'b0}}};
      f_n = 3'b100;
    end else if (s2.inf) begin
      y_n = {s2.isgn, EONE, {MW{1'b0}}};
    end else if (s2.sum == '0) begin
      y_n = {s2.zsgn, {(W-1){1'b0}}};
    end else if (ex >= EMAX) begin
      y_n = {s2.sgn, EONE, {MW{1'b0}}};
      f_n = 3'b010;
    end else if (ex[XW-1] || ex == '0) begin
      y_n = {s2.sgn, {(W-1){1'b0}}};
      f_n = 3'b001;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      out_valid <= 1'b0;
      s1 <= '0;
      s2 <= '0;
      y <= '0;
      flags <= '0;
    end else if (en) begin
      v1 <= in_valid;
      v2 <= v1;
      out_valid <= v2;
      if (in_valid) s1 <= s1_n;
      if (v1) s2 <= s2_n;
      if (v2) begin
        y <= y_n;
        flags <= f_n;
      end
    end
  end

endmodule
